// File: rtl/aes_pkg.sv
// Shared AES constants, mode encodings and GF(2^8) helpers (S-box and inverse S-box).
// Combinational helpers only; used by key_expansion and the inverse round.
package aes_pkg;

    localparam logic [1:0] AES_MODE_128 = 2'b00;
    localparam logic [1:0] AES_MODE_192 = 2'b01;
    localparam logic [1:0] AES_MODE_256 = 2'b10;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam int ROUND_KEYS_W = 1920;
    localparam int BLOCK_W      = 128;
    localparam int KEY_W        = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } dec_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // Mode 11 falls back to AES-128, matching key_expansion.
    function automatic logic [3:0] nr_of_mode(input logic [1:0] mode);
        case (mode)
            AES_MODE_192: return NR_192;
            AES_MODE_256: return NR_256;
            default:      return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// Start/done request bundle between a host and the AES decryptor.
// err exists only when AES_DEC_MODE_CHECK_EN is defined.
interface aes_decrypt_if;
    import aes_pkg::*;

    logic               start;
    logic [1:0]         mode;
    logic [BLOCK_W-1:0] ciphertext;
    logic [KEY_W-1:0]   key;
    logic [BLOCK_W-1:0] plaintext;
    logic               done;
    logic               busy;
`ifdef AES_DEC_MODE_CHECK_EN
    logic               err;

    modport master (output start, mode, ciphertext, key, input plaintext, done, busy, err);
    modport slave  (input start, mode, ciphertext, key, output plaintext, done, busy, err);
`else
    modport master (output start, mode, ciphertext, key, input plaintext, done, busy);
    modport slave  (input start, mode, ciphertext, key, output plaintext, done, busy);
`endif
endinterface

// File: rtl/aes_decrypt_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Zero latency; no handshake.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               last,
    output logic [BLOCK_W-1:0] state_nxt
);

    function automatic logic [BLOCK_W-1:0] inv_round(input logic [BLOCK_W-1:0] s,
                                                     input logic [BLOCK_W-1:0] rk,
                                                     input logic               lst);
        logic [7:0]         a [16];
        logic [BLOCK_W-1:0] o;
        int                 src;
        o = '0;
        // Byte k is row k%4, column k/4; row r rotates right by r.
        for (int k = 0; k < 16; k++) begin
            src  = (k % 4) + 4 * (((k / 4) - (k % 4) + 4) % 4);
            a[k] = inv_sbox(s[BLOCK_W-1-8*src -: 8]) ^ rk[BLOCK_W-1-8*k -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            if (lst) begin
                for (int r = 0; r < 4; r++) o[BLOCK_W-1-8*(4*c+r) -: 8] = a[4*c+r];
            end else begin
                o[BLOCK_W-1-8*(4*c+0) -: 8] = gmul(a[4*c], 8'h0e) ^ gmul(a[4*c+1], 8'h0b) ^
                                              gmul(a[4*c+2], 8'h0d) ^ gmul(a[4*c+3], 8'h09);
                o[BLOCK_W-1-8*(4*c+1) -: 8] = gmul(a[4*c], 8'h09) ^ gmul(a[4*c+1], 8'h0e) ^
                                              gmul(a[4*c+2], 8'h0b) ^ gmul(a[4*c+3], 8'h0d);
                o[BLOCK_W-1-8*(4*c+2) -: 8] = gmul(a[4*c], 8'h0d) ^ gmul(a[4*c+1], 8'h09) ^
                                              gmul(a[4*c+2], 8'h0e) ^ gmul(a[4*c+3], 8'h0b);
                o[BLOCK_W-1-8*(4*c+3) -: 8] = gmul(a[4*c], 8'h0b) ^ gmul(a[4*c+1], 8'h0d) ^
                                              gmul(a[4*c+2], 8'h09) ^ gmul(a[4*c+3], 8'h0e);
            end
        end
        return o;
    endfunction

    assign state_nxt = inv_round(state, round_key, last);

endmodule

// File: rtl/key_expansion.sv
// Combinational AES key schedule for 128/192/256-bit left-aligned keys (shared with the encryptor).
// Round key i sits at round_keys[1919-128*i -: 128]; mode 11 expands as AES-128.
module key_expansion
    import aes_pkg::*;
(
    input  logic [1:0]              mode,
    input  logic [KEY_W-1:0]        key,
    output logic [ROUND_KEYS_W-1:0] round_keys
);

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [ROUND_KEYS_W-1:0] expand(input logic [1:0] m, input logic [KEY_W-1:0] k);
        logic [31:0]             w [60];
        logic [31:0]             t;
        logic [7:0]              rc;
        logic [ROUND_KEYS_W-1:0] r;
        int                      nk;
        int                      cnt;
        nk  = (m == AES_MODE_192) ? 6 : (m == AES_MODE_256) ? 8 : 4;
        rc  = 8'h01;
        cnt = 0;
        r   = '0;
        for (int j = 0; j < 60; j++) w[j] = 32'h0;
        for (int j = 0; j < 8; j++)  w[j] = k[KEY_W-1-32*j -: 32];
        // cnt tracks j mod nk without a divider; rc advances once per schedule row.
        for (int j = 4; j < 60; j++) begin
            if (j >= nk) begin
                t = w[j-1];
                if (cnt == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime(rc);
                end else if (nk == 8 && cnt == 4) begin
                    t = sub_word(t);
                end
                w[j] = w[j-nk] ^ t;
                cnt  = (cnt == nk - 1) ? 0 : cnt + 1;
            end
        end
        for (int j = 0; j < 60; j++) r[ROUND_KEYS_W-1-32*j -: 32] = w[j];
        return r;
    endfunction

    assign round_keys = expand(mode, key);

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock; done/plaintext after Nr edges.
// start is ignored while busy (no queueing). Optional AES_DEC_MODE_CHECK_EN refuses mode 11 with err.
module aes_decrypt_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    aes_decrypt_if.slave bus
);

    dec_state_e              fsm;
    logic [BLOCK_W-1:0]      state;
    logic [3:0]              round;
    logic [BLOCK_W-1:0]      pt_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ROUND_KEYS_W-1:0] round_keys;
    logic [3:0]              nr_sel;
    logic [3:0]              rk_idx;
    logic [BLOCK_W-1:0]      rk;
    logic [BLOCK_W-1:0]      round_out;
    logic                    accept;

    key_expansion u_key_expansion (
        .mode       (bus.mode),
        .key        (bus.key),
        .round_keys (round_keys)
    );

    assign nr_sel = nr_of_mode(bus.mode);
    // Idle selects rk[Nr] for the initial whitening; in flight the counter is the key index.
    assign rk_idx = (fsm == ST_IDLE) ? nr_sel : round;
    assign rk     = round_keys[ROUND_KEYS_W-1 - BLOCK_W*int'(rk_idx) -: BLOCK_W];

    aes_inv_round u_inv_round (
        .state     (state),
        .round_key (rk),
        .last      (fsm == ST_FINAL),
        .state_nxt (round_out)
    );

`ifdef AES_DEC_MODE_CHECK_EN
    logic err_q;
    assign accept  = bus.start && !busy_q && (bus.mode != 2'b11);
    assign bus.err = err_q;
`else
    assign accept  = bus.start && !busy_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm    <= ST_IDLE;
            state  <= '0;
            round  <= '0;
            pt_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef AES_DEC_MODE_CHECK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= bus.ciphertext ^ rk;
                        round  <= nr_sel - 4'd1;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        fsm    <= ST_ROUND;
`ifdef AES_DEC_MODE_CHECK_EN
                        err_q  <= 1'b0;
                    end else if (bus.start) begin
                        err_q  <= 1'b1;
`endif
                    end
                end
                ST_ROUND: begin
                    state <= round_out;
                    round <= round - 4'd1;
                    if (round == 4'd1) fsm <= ST_FINAL;
                end
                ST_FINAL: begin
                    pt_q   <= round_out;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    fsm    <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Directed + randomized bench for aes_decrypt_top; round-trip blocks come from a behavioural AES encryptor.
// Optional AES_DEC_MODE_CHECK_EN adds the mode-11 refusal checks.
module tb_aes_decrypt_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    aes_decrypt_if bus ();

    aes_decrypt_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nk_of(input logic [1:0] m);
        return (m == 2'b01) ? 6 : (m == 2'b10) ? 8 : 4;
    endfunction

    // Textbook byte-oriented AES encryption built on the generated S-box table.
    function automatic logic [127:0] model_enc(input int nk, input logic [255:0] kk, input logic [127:0] pt);
        logic [7:0]   w [240];
        logic [7:0]   t [4];
        logic [7:0]   s [16];
        logic [7:0]   ns [16];
        logic [7:0]   rc, tmp, a0, a1, a2, a3;
        logic [127:0] o;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        o  = '0;
        for (int i = 0; i < 240; i++) w[i] = 8'h00;
        for (int i = 0; i < 4 * nk; i++) w[i] = kk[255-8*i -: 8];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            for (int b = 0; b < 4; b++) t[b] = w[4*(i-1)+b];
            if (i % nk == 0) begin
                tmp  = t[0];
                t[0] = sb[t[1]] ^ rc;
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[tmp];
                rc   = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                for (int b = 0; b < 4; b++) t[b] = sb[t[b]];
            end
            for (int b = 0; b < 4; b++) w[4*i+b] = w[4*(i-nk)+b] ^ t[b];
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j];
        for (int r = 1; r <= nr; r++) begin
            for (int j = 0; j < 16; j++) ns[j] = sb[s[(j % 4) + 4 * (((j / 4) + (j % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = ns[4*c]; a1 = ns[4*c+1]; a2 = ns[4*c+2]; a3 = ns[4*c+3];
                if (r < nr) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[16*r+j];
        end
        for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
        return o;
    endfunction

    task automatic run_block(input string tag, input logic [1:0] m, input logic [255:0] kk,
                             input logic [127:0] ct, input logic [127:0] exp_pt, input int nr);
        int   e;
        logic busy_drop;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.key = kk; bus.ciphertext = ct;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
        check({tag, " busy@accept"}, 128'(bus.busy), 128'd1);
        check({tag, " done@accept"}, 128'(bus.done), 128'd0);
        e = 0;
        busy_drop = 1'b0;
        while (!bus.done && e < 40) begin
            @(posedge clk); #1;
            e++;
            if (!bus.done && !bus.busy) busy_drop = 1'b1;
        end
        check({tag, " latency"}, 128'(e), 128'(nr));
        check({tag, " busy held"}, 128'(busy_drop), 128'd0);
        check({tag, " plaintext"}, bus.plaintext, exp_pt);
        check({tag, " busy@done"}, 128'(bus.busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   p, q, x;
        logic [255:0] rk;
        logic [127:0] rpt;
        logic         seen_done;
        int           e;
        int           n_modes;

        // S-box from the generator-3 walk: p runs over all non-zero elements, q = 1/p.
        p = 8'h01; q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;

        bus.start = 1'b0; bus.mode = 2'b00; bus.key = '0; bus.ciphertext = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 128'(bus.busy), 128'd0);
        check("reset done", 128'(bus.done), 128'd0);
        check("reset plaintext", bus.plaintext, 128'd0);
`ifdef AES_DEC_MODE_CHECK_EN
        check("reset err", 128'(bus.err), 128'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_block("kat128", 2'b00, KEY128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 10);
        run_block("kat192", 2'b01, KEY192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, 12);
        run_block("kat256", 2'b10, KEY256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, 14);

        // start held high: accepts at edges 0, 11, 22, 33; done exactly at 10, 21, 32.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b00; bus.key = KEY128;
        bus.ciphertext = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        @(posedge clk); #1;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            check($sformatf("cont done@%0d", k), 128'(bus.done), 128'((k % 11) == 10));
            if ((k % 11) == 10) check($sformatf("cont pt@%0d", k), bus.plaintext, PT);
        end
        @(negedge clk);
        bus.start = 1'b0;
        e = 0;
        while (bus.busy && e < 40) begin
            @(posedge clk); #1;
            e++;
        end
        check("cont drain", 128'(bus.busy), 128'd0);

        // Asynchronous reset at edge 5 of an AES-256 block.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b10; bus.key = KEY256;
        bus.ciphertext = 128'h8ea2b7ca516745bfeafc49904b496089;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort busy", 128'(bus.busy), 128'd0);
        check("abort done", 128'(bus.done), 128'd0);
        check("abort plaintext", bus.plaintext, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        check("abort no done", 128'(seen_done), 128'd0);
        run_block("post-reset256", 2'b10, KEY256, 128'h8ea2b7ca516745bfeafc49904b496089, PT, 14);

`ifdef AES_DEC_MODE_CHECK_EN
        n_modes = 3;
`else
        n_modes = 4;
`endif
        for (int m = 0; m < n_modes; m++) begin
            for (int r = 0; r < 2; r++) begin
                rk  = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                rpt = {$urandom(), $urandom(), $urandom(), $urandom()};
                run_block($sformatf("roundtrip m%0d #%0d", m, r), 2'(m), rk,
                          model_enc(nk_of(2'(m)), rk, rpt), rpt, nk_of(2'(m)) + 6);
            end
        end

`ifdef AES_DEC_MODE_CHECK_EN
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 2'b11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("mode11 err", 128'(bus.err), 128'd1);
        check("mode11 busy", 128'(bus.busy), 128'd0);
        check("mode11 done kept", 128'(bus.done), 128'd1);
        run_block("after-err128", 2'b00, KEY128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 10);
        check("err cleared", 128'(bus.err), 128'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
